// File: rtl/alarm_seq_if.sv
// Signal bundle between the time-keeping side and the alarm sequencer.
// Signal semantics: there is no valid/ready handshake on this bundle.
// sec_tick, btn_snooze and btn_stop are single-cycle pulses sampled on
// posedge clk. alarm_mode, in_time and arm are levels sampled every clk.
// All outputs are registered levels that change only on posedge clk or
// on an asynchronous reset.
interface alarm_seq_if;
    logic        sec_tick;
    logic [1:0]  alarm_mode;
    logic [15:0] in_time;
    logic        arm;
    logic        btn_snooze;
    logic        btn_stop;
    logic        buzzer;
    logic        ringing;
    logic        snoozing;
    logic [1:0]  snooze_cnt;
    // Observation points for the sequencer state and its time registers
    logic [1:0]  state_dbg;
    logic [15:0] target_dbg;
    logic [15:0] time_alarm_dbg;

    // master: the clock/time-keeping side that feeds the sequencer
    modport master (
        output sec_tick, alarm_mode, in_time, arm, btn_snooze, btn_stop,
        input  buzzer, ringing, snoozing, snooze_cnt,
        input  state_dbg, target_dbg, time_alarm_dbg
    );

    // slave: the alarm sequencer itself
    modport slave (
        input  sec_tick, alarm_mode, in_time, arm, btn_snooze, btn_stop,
        output buzzer, ringing, snoozing, snooze_cnt,
        output state_dbg, target_dbg, time_alarm_dbg
    );
endinterface

// File: rtl/alarm_seq.sv
// Alarm sequencer: latches the alarm time in alarm-set mode, rings with a
// 1 s on / 1 s off beep when the current time enters the target minute,
// supports a bounded number of BCD-timed snoozes, and auto-stops after
// RING_SECS seconds of ringing.
module alarm_seq #(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SECS  = 60,
    parameter int MAX_SNOOZE = 3
) (
    input logic        clk,
    input logic        rst,
    alarm_seq_if.slave alm
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SET  = 2'b11;
    localparam logic [7:0] RING_LIM  = 8'(RING_SECS);
    localparam logic [1:0] SNOOZE_LIM = 2'(MAX_SNOOZE);
    localparam logic [7:0] SNOOZE_ADD = 8'(SNOOZE_MIN);

    state_t      state, state_nxt;
    logic [15:0] time_alarm, time_alarm_nxt;
    logic [15:0] target, target_nxt;
    logic [15:0] prev_time;
    logic [7:0]  sec_cnt, sec_cnt_nxt, sec_inc;
    logic [1:0]  snooze_cnt, snooze_cnt_nxt;
    logic        buzzer, buzzer_nxt;
    logic        ringing, snoozing;
    logic        force_idle;
    logic        match;
    logic [15:0] snooze_time;

    // BCD hh:mm plus SNOOZE_MIN, minutes wrap into the hour, hour 24 wraps to 00
    function automatic logic [15:0] bcd_add_min(input logic [15:0] t);
        logic [7:0] mins;
        logic [7:0] hrs;
        mins = 8'(t[7:4]) * 8'd10 + 8'(t[3:0]) + SNOOZE_ADD;
        hrs  = 8'(t[15:12]) * 8'd10 + 8'(t[11:8]);
        if (mins >= 8'd60) begin
            mins = mins - 8'd60;
            hrs  = hrs + 8'd1;
        end
        if (hrs >= 8'd24) begin
            hrs = hrs - 8'd24;
        end
        return {4'(hrs / 8'd10), 4'(hrs % 8'd10), 4'(mins / 8'd10), 4'(mins % 8'd10)};
    endfunction

    assign force_idle  = (alm.alarm_mode == MODE_SET) || !alm.arm;
    // One match per minute entry: the time must just have changed into target
    assign match       = (alm.in_time == target) && (prev_time != target);
    assign snooze_time = bcd_add_min(alm.in_time);
    assign sec_inc     = sec_cnt + 8'd1;

    // Next-state, counters, beep phase and target selection
    always_comb begin
        state_nxt      = state;
        sec_cnt_nxt    = sec_cnt;
        snooze_cnt_nxt = snooze_cnt;
        buzzer_nxt     = 1'b0;
        target_nxt     = target;
        time_alarm_nxt = (alm.alarm_mode == MODE_SET) ? alm.in_time : time_alarm;

        if (force_idle) begin
            state_nxt      = IDLE;
            snooze_cnt_nxt = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state_nxt   = RING;
                        sec_cnt_nxt = 8'd0;
                        buzzer_nxt  = 1'b1;
                    end
                end
                RING: begin
                    if (alm.btn_stop) begin
                        state_nxt      = IDLE;
                        snooze_cnt_nxt = 2'd0;
                    end else if (alm.btn_snooze && (snooze_cnt < SNOOZE_LIM)) begin
                        state_nxt      = SNOOZE;
                        snooze_cnt_nxt = snooze_cnt + 2'd1;
                        target_nxt     = snooze_time;
                    end else if (alm.sec_tick) begin
                        sec_cnt_nxt = sec_inc;
                        if (sec_inc == RING_LIM) begin
                            state_nxt      = IDLE;
                            snooze_cnt_nxt = 2'd0;
                        end else begin
                            buzzer_nxt = ~buzzer;
                        end
                    end else begin
                        buzzer_nxt = buzzer;
                    end
                end
                SNOOZE: begin
                    if (alm.btn_stop) begin
                        state_nxt      = IDLE;
                        snooze_cnt_nxt = 2'd0;
                    end else if (match) begin
                        state_nxt   = RING;
                        sec_cnt_nxt = 8'd0;
                        buzzer_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt      = IDLE;
                    snooze_cnt_nxt = 2'd0;
                end
            endcase
        end

        // While idle the target always tracks the stored alarm time
        if (state_nxt == IDLE) begin
            target_nxt = time_alarm_nxt;
        end
    end

    // State, time registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            time_alarm <= 16'h0000;
            target     <= 16'h0000;
            prev_time  <= 16'h0000;
            sec_cnt    <= 8'd0;
            snooze_cnt <= 2'd0;
            buzzer     <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
        end else begin
            state      <= state_nxt;
            time_alarm <= time_alarm_nxt;
            target     <= target_nxt;
            prev_time  <= alm.in_time;
            sec_cnt    <= sec_cnt_nxt;
            snooze_cnt <= snooze_cnt_nxt;
            buzzer     <= buzzer_nxt;
            ringing    <= (state_nxt == RING);
            snoozing   <= (state_nxt == SNOOZE);
        end
    end

    assign alm.buzzer         = buzzer;
    assign alm.ringing        = ringing;
    assign alm.snoozing       = snoozing;
    assign alm.snooze_cnt     = snooze_cnt;
    assign alm.state_dbg      = state;
    assign alm.target_dbg     = target;
    assign alm.time_alarm_dbg = time_alarm;

endmodule

// File: tb/tb_alarm_seq.sv
// Directed bench for alarm_seq with default parameters
// (SNOOZE_MIN=5, RING_SECS=60, MAX_SNOOZE=3).
module tb_alarm_seq;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    alarm_seq_if alm();

    alarm_seq #(
        .SNOOZE_MIN(5),
        .RING_SECS (60),
        .MAX_SNOOZE(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alm(alm)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ring, input logic snz,
                           input logic buz, input logic [1:0] cnt);
        chk({tag, ".ringing"},    16'(alm.ringing),    16'(ring));
        chk({tag, ".snoozing"},   16'(alm.snoozing),   16'(snz));
        chk({tag, ".buzzer"},     16'(alm.buzzer),     16'(buz));
        chk({tag, ".snooze_cnt"}, 16'(alm.snooze_cnt), 16'(cnt));
    endtask

    task automatic pulse_tick();
        alm.sec_tick = 1'b1;
        step();
        alm.sec_tick = 1'b0;
        step();
    endtask

    task automatic set_time(input logic [15:0] t);
        alm.in_time = t;
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst            = 1'b1;
        alm.sec_tick   = 1'b0;
        alm.alarm_mode = 2'b00;
        alm.in_time    = 16'h0000;
        alm.arm        = 1'b0;
        alm.btn_snooze = 1'b0;
        alm.btn_stop   = 1'b0;

        // Reset state
        step();
        step();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        chk("reset.state", 16'(alm.state_dbg), 16'd0);
        chk("reset.target", alm.target_dbg, 16'h0000);
        chk("reset.time_alarm", alm.time_alarm_dbg, 16'h0000);
        rst = 1'b0;
        step();

        // Set alarm 07:30
        alm.alarm_mode = 2'b11;
        set_time(16'h0730);
        chk("set.time_alarm", alm.time_alarm_dbg, 16'h0730);
        chk("set.target", alm.target_dbg, 16'h0730);
        chk("set.ringing", 16'(alm.ringing), 16'd0);
        alm.alarm_mode = 2'b00;
        alm.arm        = 1'b1;
        set_time(16'h0729);
        chk("pre.ringing", 16'(alm.ringing), 16'd0);
        set_time(16'h0730);
        chk_out("trig0730", 1'b1, 1'b0, 1'b1, 2'd0);
        chk("trig0730.state", 16'(alm.state_dbg), 16'd1);

        // Beep pattern and auto-stop after 60 ticks
        pulse_tick();
        chk("tick1.buzzer", 16'(alm.buzzer), 16'd0);
        pulse_tick();
        chk("tick2.buzzer", 16'(alm.buzzer), 16'd1);
        for (int i = 3; i <= 59; i++) pulse_tick();
        chk_out("tick59", 1'b1, 1'b0, 1'b0, 2'd0);
        pulse_tick();
        chk_out("tick60", 1'b0, 1'b0, 1'b0, 2'd0);
        chk("tick60.state", 16'(alm.state_dbg), 16'd0);
        step();
        step();
        chk("noretrig.ringing", 16'(alm.ringing), 16'd0);

        // Tick coincident with trigger is not counted
        set_time(16'h0729);
        alm.in_time  = 16'h0730;
        alm.sec_tick = 1'b1;
        step();
        alm.sec_tick = 1'b0;
        chk_out("cotick", 1'b1, 1'b0, 1'b1, 2'd0);
        for (int i = 1; i <= 59; i++) pulse_tick();
        chk("cotick59.ringing", 16'(alm.ringing), 16'd1);
        pulse_tick();
        chk("cotick60.ringing", 16'(alm.ringing), 16'd0);

        // Alarm 23:58, snooze across midnight
        alm.alarm_mode = 2'b11;
        set_time(16'h2358);
        alm.alarm_mode = 2'b00;
        set_time(16'h2357);
        set_time(16'h2358);
        chk("trig2358.ringing", 16'(alm.ringing), 16'd1);
        alm.btn_snooze = 1'b1;
        step();
        alm.btn_snooze = 1'b0;
        chk_out("snz1", 1'b0, 1'b1, 1'b0, 2'd1);
        chk("snz1.target", alm.target_dbg, 16'h0003);
        set_time(16'h0002);
        chk("snz1.wait", 16'(alm.snoozing), 16'd1);
        set_time(16'h0003);
        chk_out("ring2", 1'b1, 1'b0, 1'b1, 2'd1);

        // Second and third snooze, then the fourth is ignored
        alm.btn_snooze = 1'b1;
        step();
        alm.btn_snooze = 1'b0;
        chk("snz2.target", alm.target_dbg, 16'h0008);
        chk("snz2.cnt", 16'(alm.snooze_cnt), 16'd2);
        set_time(16'h0007);
        set_time(16'h0008);
        chk("ring3.ringing", 16'(alm.ringing), 16'd1);
        alm.btn_snooze = 1'b1;
        step();
        alm.btn_snooze = 1'b0;
        chk("snz3.target", alm.target_dbg, 16'h0013);
        set_time(16'h0012);
        set_time(16'h0013);
        chk_out("ring4", 1'b1, 1'b0, 1'b1, 2'd3);
        alm.btn_snooze = 1'b1;
        step();
        alm.btn_snooze = 1'b0;
        chk_out("snz4", 1'b1, 1'b0, 1'b1, 2'd3);
        alm.btn_stop = 1'b1;
        step();
        alm.btn_stop = 1'b0;
        chk_out("stop", 1'b0, 1'b0, 1'b0, 2'd0);
        chk("stop.target", alm.target_dbg, 16'h2358);

        // Alarm 09:58, snooze with hour carry, then stop+snooze together
        alm.alarm_mode = 2'b11;
        set_time(16'h0958);
        alm.alarm_mode = 2'b00;
        set_time(16'h0957);
        set_time(16'h0958);
        alm.btn_snooze = 1'b1;
        step();
        alm.btn_snooze = 1'b0;
        chk("carry.target", alm.target_dbg, 16'h1003);
        set_time(16'h1002);
        set_time(16'h1003);
        chk("carry.ringing", 16'(alm.ringing), 16'd1);
        alm.btn_snooze = 1'b1;
        alm.btn_stop   = 1'b1;
        step();
        alm.btn_snooze = 1'b0;
        alm.btn_stop   = 1'b0;
        chk_out("both", 1'b0, 1'b0, 1'b0, 2'd0);

        // Disarm while ringing forces idle
        set_time(16'h0957);
        set_time(16'h0958);
        chk("rearm.ringing", 16'(alm.ringing), 16'd1);
        alm.arm = 1'b0;
        step();
        chk_out("disarm", 1'b0, 1'b0, 1'b0, 2'd0);
        alm.arm = 1'b1;

        // Buttons in idle are ignored
        alm.btn_snooze = 1'b1;
        step();
        alm.btn_snooze = 1'b0;
        chk_out("idlebtn", 1'b0, 1'b0, 1'b0, 2'd0);

        // Asynchronous reset between edges while ringing
        set_time(16'h0957);
        set_time(16'h0958);
        chk("prerst.ringing", 16'(alm.ringing), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_out("asyncrst", 1'b0, 1'b0, 1'b0, 2'd0);
        chk("asyncrst.time_alarm", alm.time_alarm_dbg, 16'h0000);
        #1;
        rst = 1'b0;
        step();
        step();
        chk("postrst.ringing", 16'(alm.ringing), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alarm_seq.md
ALARM_SEQ -- requirements
Module: alarm_seq

Interface
REQ-001: Parameter SNOOZE_MIN, default 5, snooze delay in minutes (legal 1..59).
REQ-002: Parameter RING_SECS, default 60, seconds of ringing before auto-stop (legal 2..255).
REQ-003: Parameter MAX_SNOOZE, default 3, maximum snoozes per alarm event (legal 0..3).
REQ-004: clk  input  1  system clock; all state changes on posedge clk.
REQ-005: rst  input  1  reset, asynchronous and active-high.
REQ-006: sec_tick  input  1  one-cycle pulse, once per second.
REQ-007: alarm_mode  input  2  clock mode; 2'b11 means alarm-set mode.
REQ-008: in_time  input  16  current time, BCD hhhh_hhhh_mmmm_mmmm (00:00..23:59).
REQ-009: arm  input  1  level; 1 enables alarm triggering.
REQ-010: btn_snooze  input  1  one-cycle debounced snooze pulse.
REQ-011: btn_stop  input  1  one-cycle debounced stop pulse.
REQ-012: buzzer  output  1  audible drive, beep pattern.
REQ-013: ringing  output  1  high in state RING.
REQ-014: snoozing  output  1  high in state SNOOZE.
REQ-015: snooze_cnt  output  2  snoozes used in current event.

Function
REQ-016: Register time_alarm SHALL load in_time on every clk where alarm_mode==2'b11, else hold.
REQ-017: Register target SHALL equal time_alarm whenever state is IDLE.
REQ-018: Register prev_time SHALL capture in_time every clk; match = (in_time==target) && (prev_time!=target) (one match per minute entry).
REQ-019: States SHALL be IDLE, RING, SNOOZE; encoding free.
REQ-020: IDLE -> RING on match && arm && alarm_mode!=2'b11; sec counter and buzzer phase cleared.
REQ-021: In RING, buzzer SHALL be 1 during the first second after entry and toggle on each sec_tick (1 s on / 1 s off).
REQ-022: In RING, each sec_tick increments an 8-bit sec counter; when counter reaches RING_SECS -> IDLE, snooze_cnt cleared.
REQ-023: In RING, btn_snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1, target = in_time + SNOOZE_MIN; btn_snooze with snooze_cnt==MAX_SNOOZE ignored.
REQ-024: Snooze add SHALL be BCD: minutes >=60 wrap minus 60 with hour carry; hour 24 wraps to 00 (23:58 + 5 = 00:03).
REQ-025: In SNOOZE, buzzer=0; match && arm -> RING (sec counter, phase cleared; snooze_cnt held).
REQ-026: btn_stop in RING or SNOOZE -> IDLE, snooze_cnt=0, buzzer=0 next cycle.
REQ-027: btn_stop and btn_snooze same cycle: stop wins.
REQ-028: alarm_mode==2'b11 or arm==0 in any state SHALL force IDLE next cycle, snooze_cnt=0; takes priority over all other transitions.
REQ-029: sec_tick coincident with match in IDLE: enter RING, that tick not counted.
REQ-030: buzzer, ringing, snoozing SHALL be registered outputs, 1-cycle latency from the transition cause.
REQ-031: Buttons in IDLE SHALL be ignored.

Reset
REQ-032: rst high SHALL immediately set state IDLE, time_alarm=16'h0000, target=16'h0000, prev_time=16'h0000, sec counter=0, snooze_cnt=0, buzzer=0, ringing=0, snoozing=0.
REQ-033: rst deasserted mid-RING SHALL not resume ringing; re-trigger only on a new match.

Verification
REQ-034: mode=3,in_time=16'h0730 one clk; mode=0, arm=1, in_time 0729->0730 -> ringing=1, buzzer=1 next cycle; buzzer toggles per sec_tick.
REQ-035: Ringing, no buttons, 60 sec_ticks -> IDLE, buzzer=0, ringing=0; in_time held 0730 does not re-trigger.
REQ-036: Alarm 23:58 ringing, btn_snooze -> snoozing=1, snooze_cnt=1, target=16'h0003; in_time 0002->0003 -> ringing=1.
REQ-037: Snooze 3 times then 4th btn_snooze -> stays RING, snooze_cnt=3; btn_stop -> IDLE, snooze_cnt=0.
REQ-038: btn_snooze and btn_stop same cycle in RING -> IDLE, snooze_cnt=0.
REQ-039: rst pulse (async, between clk edges) while ringing -> all outputs 0 before next clk edge; time_alarm=0000.
